// File: rtl/bcd_hex_pkg.sv
// Shared constants and helpers for the BCD up/down counter with 7-segment output.
// Segment patterns are active-low with bit6 = a down to bit0 = g.
package bcd_hex_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Map one BCD digit to its segment pattern; non-decimal codes show blank.
  function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Force illegal BCD codes (10..15) to zero so the counter never holds them.
  function automatic logic [3:0] bcd_sanitize(input logic [3:0] digit);
    logic [3:0] res;
    if (digit > 4'd9) begin
      res = 4'd0;
    end else begin
      res = digit;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the ripple counter: holds its nibble, steps up or down
// when asked, and reports carry/borrow to the next more significant digit.
module bcd_digit_cell
  import bcd_hex_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       step_i,
  input  logic       up_i,
  input  logic       load_i,
  input  logic [3:0] load_nibble_i,
  output logic [3:0] nibble_o,
  output logic       carry_o,
  output logic       borrow_o
);

  logic [3:0] nibble_q;
  logic [3:0] nibble_d;

  // Next digit value: load beats step, step wraps 9->0 (up) or 0->9 (down).
  always_comb begin
    nibble_d = nibble_q;
    if (load_i) begin
      nibble_d = bcd_sanitize(load_nibble_i);
    end else if (step_i) begin
      if (up_i) begin
        nibble_d = (nibble_q == 4'd9) ? 4'd0 : (nibble_q + 4'd1);
      end else begin
        nibble_d = (nibble_q == 4'd0) ? 4'd9 : (nibble_q - 4'd1);
      end
    end else begin
      nibble_d = nibble_q;
    end
  end

  // Digit storage with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      nibble_q <= 4'd0;
    end else begin
      nibble_q <= nibble_d;
    end
  end

  assign nibble_o = nibble_q;
  assign carry_o  = step_i &  up_i & (nibble_q == 4'd9);
  assign borrow_o = step_i & ~up_i & (nibble_q == 4'd0);

endmodule

// File: rtl/bcd_updown_counter_hex.sv
// Multi-digit BCD up/down counter with integrated prescaler, parallel load,
// wrap pulse and registered active-low 7-segment outputs.
module bcd_updown_counter_hex
  import bcd_hex_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 1,
  parameter int BLANK_LZ = 0
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  SW_UP,
  input  logic                  SW_EN,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [4*DIGITS-1:0]   BCD,
  output logic [7*DIGITS-1:0]   HEX,
  output logic                  TICK,
  output logic                  WRAP
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  // Display value shown while in reset: "0" everywhere, or only on digit 0
  // when leading zeros are blanked.
  function automatic logic [7*DIGITS-1:0] hex_reset_value();
    logic [7*DIGITS-1:0] v;
    v = {(7*DIGITS){1'b1}};
    for (int i = 0; i < DIGITS; i++) begin
      if ((BLANK_LZ != 0) && (i != 0)) begin
        v[7*i +: 7] = SEG_BLANK;
      end else begin
        v[7*i +: 7] = SEG_0;
      end
    end
    return v;
  endfunction

  localparam logic [7*DIGITS-1:0] HEX_RST = hex_reset_value();

  logic [PW-1:0]         presc_q;
  logic [PW-1:0]         presc_d;
  logic                  tick_q;
  logic                  tick_d;
  logic                  wrap_q;
  logic                  wrap_d;
  logic [7*DIGITS-1:0]   hex_q;
  logic [7*DIGITS-1:0]   hex_d;
  logic [4*DIGITS-1:0]   bcd_s;

  // Digit chain: digit 0 steps on an enabled tick, higher digits step on the
  // carry/borrow of the digit below. Per-scope signals keep the ripple acyclic.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic step_s;
    logic carry_s;
    logic borrow_s;

    if (gi == 0) begin : g_lsd
      assign step_s = tick_q & SW_EN;
    end else begin : g_upper
      assign step_s = g_digit[gi-1].carry_s | g_digit[gi-1].borrow_s;
    end

    bcd_digit_cell u_cell (
      .clk_i         (CLOCK_50),
      .rst_i         (RESET),
      .step_i        (step_s),
      .up_i          (SW_UP),
      .load_i        (LOAD),
      .load_nibble_i (LOAD_VAL[4*gi +: 4]),
      .nibble_o      (bcd_s[4*gi +: 4]),
      .carry_o       (carry_s),
      .borrow_o      (borrow_s)
    );
  end

  // Prescaler next state and tick strobe at the last count of each period.
  always_comb begin
    if (presc_q == PRESC_LAST) begin
      presc_d = {PW{1'b0}};
      tick_d  = 1'b1;
    end else begin
      presc_d = presc_q + PW'(1);
      tick_d  = 1'b0;
    end
  end

  // A carry/borrow out of the top digit means the whole range wrapped; a
  // load in the same cycle overrides the step, so no wrap then.
  always_comb begin
    if (LOAD) begin
      wrap_d = 1'b0;
    end else begin
      wrap_d = g_digit[DIGITS-1].carry_s | g_digit[DIGITS-1].borrow_s;
    end
  end

  // Segment decode of the current count, blanking zeros above the highest
  // non-zero digit when enabled (digit 0 always shown).
  always_comb begin
    logic nz_v;
    hex_d = {(7*DIGITS){1'b1}};
    nz_v  = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz_v = nz_v | (bcd_s[4*i +: 4] != 4'd0);
      if ((BLANK_LZ != 0) && (i != 0) && !nz_v) begin
        hex_d[7*i +: 7] = SEG_BLANK;
      end else begin
        hex_d[7*i +: 7] = seg7_decode(bcd_s[4*i +: 4]);
      end
    end
  end

  // Prescaler, strobes and display registers with asynchronous clear.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      presc_q <= {PW{1'b0}};
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      hex_q   <= HEX_RST;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      hex_q   <= hex_d;
    end
  end

  assign BCD  = bcd_s;
  assign HEX  = hex_q;
  assign TICK = tick_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter_hex.sv
// Self-checking bench: directed scenarios followed by random stimulus, all
// compared against a decimal-integer reference model of the counter.
module tb_bcd_updown_counter_hex;

  logic        clk;
  logic        rst;
  logic        up;
  logic        en;
  logic        load;
  logic [7:0]  load_val;
  logic [7:0]  bcd_a;
  logic [13:0] hex_a;
  logic        tick_a;
  logic        wrap_a;
  logic [7:0]  bcd_b;
  logic [13:0] hex_b;
  logic        tick_b;
  logic        wrap_b;

  int errors = 0;
  int checks = 0;

  // Reference model state: the count as a plain decimal integer.
  int m_val;
  int m_presc;
  int m_hexval;
  bit m_tick;
  bit m_wrap;

  bcd_updown_counter_hex #(.DIGITS(2), .CLK_HZ(10), .TICK_HZ(1), .BLANK_LZ(0)) u_dut (
    .CLOCK_50 (clk), .RESET (rst), .SW_UP (up), .SW_EN (en), .LOAD (load),
    .LOAD_VAL (load_val), .BCD (bcd_a), .HEX (hex_a), .TICK (tick_a), .WRAP (wrap_a)
  );

  bcd_updown_counter_hex #(.DIGITS(2), .CLK_HZ(10), .TICK_HZ(1), .BLANK_LZ(1)) u_dut_blank (
    .CLOCK_50 (clk), .RESET (rst), .SW_UP (up), .SW_EN (en), .LOAD (load),
    .LOAD_VAL (load_val), .BCD (bcd_b), .HEX (hex_b), .TICK (tick_b), .WRAP (wrap_b)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'b0000001;
      1: s = 7'b1001111;
      2: s = 7'b0010010;
      3: s = 7'b0000110;
      4: s = 7'b1001100;
      5: s = 7'b0100100;
      6: s = 7'b0100000;
      7: s = 7'b0001111;
      8: s = 7'b0000000;
      9: s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic int san(input logic [3:0] n);
    return (n > 4'd9) ? 0 : int'(n);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [13:0] hex_exp(input int v, input bit blank);
    logic [6:0] tens;
    tens = (blank && (v < 10)) ? 7'b1111111 : seg_of(v / 10);
    return {tens, seg_of(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_val    = 0;
    m_presc  = 0;
    m_tick   = 1'b0;
    m_wrap   = 1'b0;
    m_hexval = 0;
  endtask

  task automatic check_all();
    chk("bcd", 32'(bcd_a), 32'(to_bcd(m_val)));
    chk("bcd_blank", 32'(bcd_b), 32'(to_bcd(m_val)));
    chk("tick", 32'(tick_a), 32'(m_tick));
    chk("tick_blank", 32'(tick_b), 32'(m_tick));
    chk("wrap", 32'(wrap_a), 32'(m_wrap));
    chk("wrap_blank", 32'(wrap_b), 32'(m_wrap));
    chk("hex", 32'(hex_a), 32'(hex_exp(m_hexval, 1'b0)));
    chk("hex_blank", 32'(hex_b), 32'(hex_exp(m_hexval, 1'b1)));
  endtask

  // Advance one clock, update the model from the inputs seen at the edge,
  // then compare everything just after the edge.
  task automatic cyc();
    bit old_tick;
    int old_val;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      old_tick = m_tick;
      old_val  = m_val;
      m_tick   = (m_presc == 9);
      m_presc  = (m_presc + 1) % 10;
      m_hexval = old_val;
      if (load) begin
        m_val  = san(load_val[7:4]) * 10 + san(load_val[3:0]);
        m_wrap = 1'b0;
      end else if (old_tick && en) begin
        if (up) begin
          m_wrap = (old_val == 99);
          m_val  = (old_val + 1) % 100;
        end else begin
          m_wrap = (old_val == 0);
          m_val  = (old_val + 99) % 100;
        end
      end else begin
        m_wrap = 1'b0;
      end
    end
    #1;
    check_all();
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (!tick_a && n < 20) begin
      cyc();
      n++;
    end
    chk("tick_seen", 32'(tick_a), 32'd1);
  endtask

  task automatic do_load(input logic [7:0] v);
    load_val = v;
    load     = 1'b1;
    cyc();
    load     = 1'b0;
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    up       = 1'b1;
    en       = 1'b1;
    load     = 1'b0;
    load_val = 8'h00;
    #1;
    model_reset();
    check_all();
    cyc();
    cyc();

    // Release between edges and measure the first tick latency.
    #3 rst = 1'b0;
    n = 0;
    while (!tick_a && n < 30) begin
      cyc();
      n++;
    end
    chk("first_tick_latency", 32'(n), 32'd10);

    // Ten ticks of counting up from 0x00 lands on 0x10.
    repeat (100) cyc();
    chk("up_to_10", 32'(bcd_a), 32'h10);

    // Up-wrap from 0x99 to 0x00.
    do_load(8'h98);
    chk("load_98", 32'(bcd_a), 32'h98);
    n = 0;
    while (!wrap_a && n < 40) begin
      cyc();
      n++;
    end
    chk("wrap_up_seen", 32'(wrap_a), 32'd1);
    chk("wrap_up_value", 32'(bcd_a), 32'h00);
    cyc();
    chk("wrap_up_one_cycle", 32'(wrap_a), 32'd0);

    // Down-wrap from 0x00 to 0x99, then 0x98.
    up = 1'b0;
    n = 0;
    while (!wrap_a && n < 40) begin
      cyc();
      n++;
    end
    chk("wrap_down_seen", 32'(wrap_a), 32'd1);
    chk("wrap_down_value", 32'(bcd_a), 32'h99);
    wait_tick();
    cyc();
    chk("down_98", 32'(bcd_a), 32'h98);

    // Borrow across digits: 0x10 down to 0x09.
    do_load(8'h10);
    wait_tick();
    cyc();
    chk("down_borrow_09", 32'(bcd_a), 32'h09);

    // Load coincident with a tick: load wins, illegal nibble sanitised.
    up = 1'b1;
    wait_tick();
    do_load(8'h3F);
    chk("load_on_tick", 32'(bcd_a), 32'h30);
    cyc();
    chk("load_on_tick_no_inc", 32'(bcd_a), 32'h30);

    // Disabled counting holds across several ticks.
    en = 1'b0;
    repeat (35) cyc();
    chk("enable_hold", 32'(bcd_a), 32'h30);

    // Leading-zero blanking.
    do_load(8'h05);
    cyc();
    chk("blank_tens_05", 32'(hex_b[13:7]), 32'h7F);
    chk("blank_ones_05", 32'(hex_b[6:0]), 32'(7'b0100100));
    do_load(8'h00);
    cyc();
    chk("blank_ones_00", 32'(hex_b[6:0]), 32'(7'b0000001));

    // Asynchronous reset mid-prescale at 0x47.
    do_load(8'h47);
    repeat (3) cyc();
    chk("pre_reset_47", 32'(bcd_a), 32'h47);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_bcd", 32'(bcd_a), 32'h00);
    chk("async_rst_tick", 32'(tick_a), 32'd0);
    chk("async_rst_hex", 32'(hex_a), 32'(14'b0000001_0000001));
    cyc();
    #3 rst = 1'b0;
    en = 1'b1;
    n = 0;
    while (!tick_a && n < 30) begin
      cyc();
      n++;
    end
    chk("post_rst_tick_latency", 32'(n), 32'd10);

    // Random stimulus, with loads biased toward the wrap boundaries.
    repeat (400) begin
      en   = ($urandom_range(0, 7) != 0);
      up   = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       load_val = 8'h99;
        1:       load_val = 8'h00;
        default: load_val = 8'($urandom);
      endcase
      cyc();
    end
    load = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
